// File: rtl/irq_pkg.sv
// Shared constants for the irq_ctl interrupt controller: register map and source count.
package irq_pkg;

    localparam int unsigned IRQ_NSRC = 7;
    localparam int unsigned IRQ_DW   = 8;

    localparam logic [1:0] IRQ_STATUS = 2'd0;
    localparam logic [1:0] IRQ_ENABLE = 2'd1;
    localparam logic [1:0] IRQ_MODE   = 2'd2;
    localparam logic [1:0] IRQ_VECTOR = 2'd3;

    localparam logic [IRQ_DW-1:0] IRQ_NONE = 8'h80;

endpackage

// File: rtl/sync_ff.sv
// Single-bit N-stage synchroniser with asynchronous active-low reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_ctl.sv
// 65C02 interrupt controller: seven level/edge sources plus NMI, four mapped registers,
// registered IRQ/NMI and one-cycle registered read data.
module irq_ctl
    import irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                CS,
    input  logic [1:0]          A,
    input  logic                WE,
    input  logic [IRQ_DW-1:0]   WD,
    input  logic                RDY,
    output logic [IRQ_DW-1:0]   DO,
    input  logic [IRQ_NSRC-1:0] SRC,
    input  logic                NMI_IN,
    output logic                IRQ,
    output logic                NMI
);

    // Bit IRQ_NSRC of the synchroniser vectors carries NMI_IN.
    logic [IRQ_NSRC:0]   raw;
    logic [IRQ_NSRC:0]   sync_q;
    logic [IRQ_NSRC:0]   prev_q;
    logic [IRQ_NSRC:0]   rise_c;

    logic [IRQ_NSRC-1:0] pend;
    logic [IRQ_NSRC-1:0] enable;
    logic [IRQ_NSRC-1:0] mode;
    logic                nmi_pend;

    logic                wr_c;
    logic                rd_c;
    logic [IRQ_DW-1:0]   clr_c;
    logic [IRQ_NSRC-1:0] sw_set_c;
    logic [IRQ_NSRC-1:0] mode_nxt_c;
    logic [IRQ_NSRC-1:0] en_nxt_c;
    logic [IRQ_NSRC-1:0] edge_nxt_c;
    logic [IRQ_NSRC-1:0] pend_nxt_c;
    logic                nmi_nxt_c;
    logic [IRQ_DW-1:0]   vec_c;
    logic [IRQ_DW-1:0]   rdata_c;

    assign raw = {NMI_IN, SRC};

    for (genvar g = 0; g <= IRQ_NSRC; g++) begin : g_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (RST),
            .d     (raw[g]),
            .q     (sync_q[g])
        );
    end

    assign rise_c = sync_q & ~prev_q;

    // Next-state for pending/config registers and read mux.
    always_comb begin
        wr_c       = CS & WE & RDY;
        rd_c       = CS & ~WE & RDY;
        clr_c      = (wr_c && A == IRQ_STATUS) ? WD : '0;
        sw_set_c   = (wr_c && A == IRQ_VECTOR) ? WD[IRQ_NSRC-1:0] : '0;
        mode_nxt_c = (wr_c && A == IRQ_MODE)   ? WD[IRQ_NSRC-1:0] : mode;
        en_nxt_c   = (wr_c && A == IRQ_ENABLE) ? WD[IRQ_NSRC-1:0] : enable;

        // Set beats clear in edge mode; a bit newly switched to edge mode starts clear.
        edge_nxt_c = (pend & ~clr_c[IRQ_NSRC-1:0]) | rise_c[IRQ_NSRC-1:0] | sw_set_c;
        pend_nxt_c = (mode & edge_nxt_c) | (~mode & sync_q[IRQ_NSRC-1:0]);
        pend_nxt_c = pend_nxt_c & ~(mode_nxt_c & ~mode);
        nmi_nxt_c  = (nmi_pend & ~clr_c[IRQ_NSRC]) | rise_c[IRQ_NSRC];

        vec_c = IRQ_NONE;
        for (int i = int'(IRQ_NSRC) - 1; i >= 0; i--) begin
            if (pend[i] && enable[i]) begin
                vec_c = IRQ_DW'(i);
            end
        end

        case (A)
            IRQ_STATUS: rdata_c = {nmi_pend, pend};
            IRQ_ENABLE: rdata_c = {1'b0, enable};
            IRQ_MODE:   rdata_c = {1'b0, mode};
            default:    rdata_c = vec_c;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            prev_q   <= '0;
            pend     <= '0;
            enable   <= '0;
            mode     <= '0;
            nmi_pend <= 1'b0;
            IRQ      <= 1'b0;
            NMI      <= 1'b0;
            DO       <= '0;
        end else begin
            prev_q   <= sync_q;
            pend     <= pend_nxt_c;
            enable   <= en_nxt_c;
            mode     <= mode_nxt_c;
            nmi_pend <= nmi_nxt_c;
            IRQ      <= |(pend & enable);
            NMI      <= nmi_pend;
            if (rd_c) begin
                DO <= rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: rule-level model checked every cycle plus directed literal checks.
module tb_irq_ctl;

    localparam int unsigned SS = 2;

    logic       clk    = 1'b1;
    logic       RST    = 1'b1;
    logic       CS     = 1'b0;
    logic [1:0] A      = 2'd0;
    logic       WE     = 1'b0;
    logic [7:0] WD     = 8'h00;
    logic       RDY    = 1'b1;
    logic [6:0] SRC    = 7'h00;
    logic       NMI_IN = 1'b0;
    logic [7:0] DO;
    logic       IRQ;
    logic       NMI;

    irq_ctl #(.SYNC_STAGES(SS)) dut (
        .clk    (clk),
        .RST    (RST),
        .CS     (CS),
        .A      (A),
        .WE     (WE),
        .WD     (WD),
        .RDY    (RDY),
        .DO     (DO),
        .SRC    (SRC),
        .NMI_IN (NMI_IN),
        .IRQ    (IRQ),
        .NMI    (NMI)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw input samples in a delay line; hist[k] is the sample taken k+1 edges ago.
    logic [7:0] hist [0:SS];
    logic [6:0] m_pend  = '0;
    logic       m_npend = 1'b0;
    logic [6:0] m_en    = '0;
    logic [6:0] m_mode  = '0;
    logic [7:0] m_do    = '0;
    logic       m_irq   = 1'b0;
    logic       m_nmi   = 1'b0;
    logic [7:0] m_sync;
    logic [7:0] m_prev;
    logic [6:0] m_np;
    logic       m_wr;

    initial for (int k = 0; k <= SS; k++) hist[k] = 8'h00;

    function automatic logic [7:0] m_read(input logic [1:0] a);
        logic [7:0] r;
        logic       found;
        case (a)
            2'd0: r = {m_npend, m_pend};
            2'd1: r = {1'b0, m_en};
            2'd2: r = {1'b0, m_mode};
            default: begin
                r = 8'h80;
                found = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    if (!found && m_pend[i] && m_en[i]) begin
                        r = 8'(i);
                        found = 1'b1;
                    end
                end
            end
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k <= SS; k++) hist[k] = 8'h00;
            m_pend = '0; m_npend = 1'b0; m_en = '0; m_mode = '0;
            m_do = '0; m_irq = 1'b0; m_nmi = 1'b0;
        end else begin
            m_sync = hist[SS-1];
            m_prev = hist[SS];
            m_wr   = CS && WE && RDY;
            m_irq  = |(m_pend & m_en);
            m_nmi  = m_npend;
            if (CS && !WE && RDY) m_do = m_read(A);
            for (int i = 0; i < 7; i++) begin
                if (!m_mode[i]) begin
                    m_np[i] = m_sync[i];
                end else begin
                    m_np[i] = m_pend[i];
                    if (m_wr && A == 2'd0 && WD[i]) m_np[i] = 1'b0;
                    if (m_sync[i] && !m_prev[i]) m_np[i] = 1'b1;
                    if (m_wr && A == 2'd3 && WD[i]) m_np[i] = 1'b1;
                end
                if (m_wr && A == 2'd2 && WD[i] && !m_mode[i]) m_np[i] = 1'b0;
            end
            if (m_wr && A == 2'd0 && WD[7]) m_npend = 1'b0;
            if (m_sync[7] && !m_prev[7]) m_npend = 1'b1;
            if (m_wr && A == 2'd2) m_mode = WD[6:0];
            if (m_wr && A == 2'd1) m_en = WD[6:0];
            m_pend = m_np;
            for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {NMI_IN, SRC};
        end
    end

    always @(negedge clk) begin
        check("model_do", DO, m_do);
        check("model_irq", {7'b0, IRQ}, {7'b0, m_irq});
        check("model_nmi", {7'b0, NMI}, {7'b0, m_nmi});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b1; WE = 1'b1; A = a; WD = d;
        @(negedge clk);
        CS = 1'b0; WE = 1'b0; WD = 8'h00;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        CS = 1'b1; WE = 1'b0; A = a;
        @(negedge clk);
        CS = 1'b0;
        check(name, DO, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 RST = 1'b0;
        #1;
        check("rst_do", DO, 8'h00);
        check("rst_irq", {7'b0, IRQ}, 8'h00);
        check("rst_nmi", {7'b0, NMI}, 8'h00);
        tick(2);
        RST = 1'b1;

        // Level mode
        wr(2'd1, 8'h7F);
        wr(2'd2, 8'h00);
        SRC[3] = 1'b1;
        tick(3);
        check("lvl_irq_early", {7'b0, IRQ}, 8'h00);
        tick(1);
        check("lvl_irq", {7'b0, IRQ}, 8'h01);
        rd(2'd0, 8'h08, "lvl_status");
        rd(2'd3, 8'h03, "lvl_vector");
        SRC[3] = 1'b0;
        tick(3);
        check("lvl_drop_early", {7'b0, IRQ}, 8'h01);
        tick(1);
        check("lvl_drop", {7'b0, IRQ}, 8'h00);

        // Edge mode and priority
        wr(2'd2, 8'h7F);
        SRC[5] = 1'b1; tick(1);
        SRC[5] = 1'b0; SRC[1] = 1'b1; tick(1);
        SRC[1] = 1'b0;
        tick(3);
        rd(2'd3, 8'h01, "edge_vec1");
        wr(2'd0, 8'h02);
        rd(2'd3, 8'h05, "edge_vec5");
        wr(2'd0, 8'h20);
        check("w1c_irq_hold", {7'b0, IRQ}, 8'h01);
        tick(1);
        check("w1c_irq_fall", {7'b0, IRQ}, 8'h00);
        rd(2'd3, 8'h80, "edge_vec_none");

        // W1C in the same cycle the edge lands: set wins
        SRC[2] = 1'b1;
        tick(2);
        wr(2'd0, 8'h04);
        rd(2'd0, 8'h04, "collide_status");
        SRC[2] = 1'b0;
        wr(2'd0, 8'h04);
        rd(2'd0, 8'h00, "collide_cleared");

        // NMI while stalled
        RDY = 1'b0;
        NMI_IN = 1'b1; tick(1);
        NMI_IN = 1'b0;
        tick(4);
        check("nmi_stall_set", {7'b0, NMI}, 8'h01);
        wr(2'd0, 8'h80);
        tick(2);
        check("nmi_stall_hold", {7'b0, NMI}, 8'h01);
        RDY = 1'b1;
        wr(2'd0, 8'h80);
        check("nmi_ack_pre", {7'b0, NMI}, 8'h01);
        tick(1);
        check("nmi_ack", {7'b0, NMI}, 8'h00);

        // Software trigger, then asynchronous reset
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h03);
        rd(2'd0, 8'h01, "swset_status");
        NMI_IN = 1'b1; tick(1);
        NMI_IN = 1'b0;
        tick(4);
        check("pre_rst_irq", {7'b0, IRQ}, 8'h01);
        check("pre_rst_nmi", {7'b0, NMI}, 8'h01);
        check("pre_rst_do", DO, 8'h01);
        @(posedge clk);
        #2 RST = 1'b0;
        #1;
        check("async_rst_irq", {7'b0, IRQ}, 8'h00);
        check("async_rst_nmi", {7'b0, NMI}, 8'h00);
        check("async_rst_do", DO, 8'h00);
        tick(2);
        RST = 1'b1;
        rd(2'd0, 8'h00, "post_rst_status");
        rd(2'd1, 8'h00, "post_rst_enable");
        rd(2'd2, 8'h00, "post_rst_mode");
        rd(2'd3, 8'h80, "post_rst_vector");
        tick(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
